// File: rtl/qmult_arbiter.sv
// Round-robin scheduler sharing one Q-format sign-magnitude multiplier among NREQ
// requesters through a two-stage pipeline, with tagged responses and sticky overflow.
module qmult_arbiter #(
    parameter int NREQ = 4,
    parameter int Q    = 12,
    parameter int N    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N-1:0]            rsp_result,
    output logic                    rsp_overflow,
    output logic [NREQ-1:0]         ovf_sticky,
    input  logic [NREQ-1:0]         ovf_clr
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]  rr;
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic [N-1:0]    s1_a;
    logic [N-1:0]    s1_b;

    logic            adv1;
    logic            adv2;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic            accept;
    logic [IDW-1:0]  rr_next;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;

    logic [N-2:0]    mag_a;
    logic [N-2:0]    mag_b;
    logic [2*N-2:0]  prod;
    logic [N-Q-1:0]  prod_ovf_bits;
    logic [N-2:0]    prod_trunc;
    logic [Q-1:0]    prod_frac_unused;
    logic            mul_sign;
    logic [N-1:0]    mul_result;
    logic            mul_overflow;
    logic [NREQ-1:0] sticky_set;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Search from rr upward with wrap; the first valid requester wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign req_ready = (rst_n && adv1) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign rr_next   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    assign sel_a     = req_a[int'(grant_id)*N +: N];
    assign sel_b     = req_b[int'(grant_id)*N +: N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr       <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_id <= grant_id;
                    s1_a  <= sel_a;
                    s1_b  <= sel_b;
                end
            end
            if (accept) begin
                rr <= rr_next;
            end
        end
    end

    // Magnitudes are the low N-1 bits of the two's-complement absolute value,
    // so the most negative operand has magnitude zero.
    always_comb begin
        mul_sign = s1_a[N-1] ^ s1_b[N-1];
        mag_a    = s1_a[N-1] ? (~s1_a[N-2:0] + (N-1)'(1)) : s1_a[N-2:0];
        mag_b    = s1_b[N-1] ? (~s1_b[N-2:0] + (N-1)'(1)) : s1_b[N-2:0];
        prod     = (2*N-1)'(mag_a) * (2*N-1)'(mag_b);
        {prod_ovf_bits, prod_trunc, prod_frac_unused} = prod;
        mul_result   = {mul_sign, mul_sign ? (~prod_trunc + (N-1)'(1)) : prod_trunc};
        mul_overflow = |prod_ovf_bits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else if (adv2) begin
            rsp_valid    <= s1_valid;
            rsp_id       <= s1_id;
            rsp_result   <= mul_result;
            rsp_overflow <= mul_overflow;
        end
    end

    always_comb begin
        sticky_set = '0;
        if (adv2 && s1_valid && mul_overflow) begin
            sticky_set[s1_id] = 1'b1;
        end
    end

    // A set in the same cycle as a clear of that bit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | sticky_set;
        end
    end

endmodule

// File: tb/tb_qmult_arbiter.sv
// Directed bench for qmult_arbiter: scoreboard of expected responses filled on
// each observed handshake and drained as responses are consumed.
module tb_qmult_arbiter;

    localparam int NREQ = 4;
    localparam int Q    = 12;
    localparam int N    = 16;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*N-1:0]    req_a;
    logic [NREQ*N-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [N-1:0]         rsp_result;
    logic                 rsp_overflow;
    logic [NREQ-1:0]      ovf_sticky;
    logic [NREQ-1:0]      ovf_clr;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           ovf;
        logic [N-1:0]   result;
    } exp_t;

    exp_t           sb_q[$];
    int             checks = 0;
    int             errors = 0;
    int             model_rr = 0;
    int             n_acc = 0;
    int             n_rsp = 0;
    logic           stall_prev = 1'b0;
    logic [IDW-1:0] prev_id;
    logic [N-1:0]   prev_result;
    logic           prev_ovf;
    logic [IDW-1:0] last_id;
    logic [N-1:0]   last_result;
    logic           last_ovf;

    qmult_arbiter #(.NREQ(NREQ), .Q(Q), .N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .ovf_sticky   (ovf_sticky),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference multiply written arithmetically on integers.
    function automatic logic [N:0] model_mult(input logic [N-1:0] a, input logic [N-1:0] b);
        longint ma, mb, p, t;
        logic   neg, ovf;
        neg = a[N-1] ^ b[N-1];
        ma  = longint'($signed(a));
        mb  = longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        ma  = ma % (longint'(1) << (N-1));
        mb  = mb % (longint'(1) << (N-1));
        p   = ma * mb;
        t   = (p >> Q) % (longint'(1) << (N-1));
        ovf = (p >> (N-1+Q)) != 0;
        if (neg) t = ((longint'(1) << (N-1)) - t) % (longint'(1) << (N-1));
        return {ovf, neg, (N-1)'(t)};
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic set_operands(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NREQ; i++) begin
            set_operands(i, 16'($urandom), 16'($urandom));
        end
    endtask

    // One clock cycle: sample just after the falling edge, then advance.
    task automatic step();
        logic [NREQ-1:0] hs;
        int              g;
        exp_t            got;
        exp_t            want;
        #1;
        if (stall_prev) begin
            check_output("stall_valid", rsp_valid, 1);
            check_output("stall_id", rsp_id, prev_id);
            check_output("stall_result", rsp_result, prev_result);
            check_output("stall_ovf", rsp_overflow, prev_ovf);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_output("spurious_rsp", rsp_valid, 0);
            end else begin
                want = sb_q.pop_front();
                got  = '{id: rsp_id, ovf: rsp_overflow, result: rsp_result};
                check_output("rsp_id", got.id, want.id);
                check_output("rsp_result", got.result, want.result);
                check_output("rsp_ovf", got.ovf, want.ovf);
                last_id     = rsp_id;
                last_result = rsp_result;
                last_ovf    = rsp_overflow;
                n_rsp++;
            end
        end
        hs = req_valid & req_ready;
        if (hs != '0) begin
            g = rr_pick(req_valid, model_rr);
            check_output("grant", hs, 32'(1) << g);
            want.id = IDW'(g);
            {want.ovf, want.result} = model_mult(req_a[g*N +: N], req_b[g*N +: N]);
            sb_q.push_back(want);
            model_rr = (g + 1) % NREQ;
            n_acc++;
        end
        stall_prev  = rsp_valid && !rsp_ready;
        prev_id     = rsp_id;
        prev_result = rsp_result;
        prev_ovf    = rsp_overflow;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int cnt;
        cnt       = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (sb_q.size() > 0 && cnt < budget) begin
            step();
            cnt++;
        end
        check_output("drain_empty", sb_q.size(), 0);
    endtask

    task automatic apply_stimulus(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        set_operands(id, a, b);
        req_valid = NREQ'(1) << id;
        step();
        req_valid = '0;
        drain(8);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_rsp_valid"}, rsp_valid, 0);
        check_output({tag, "_rsp_id"}, rsp_id, 0);
        check_output({tag, "_rsp_result"}, rsp_result, 0);
        check_output({tag, "_rsp_ovf"}, rsp_overflow, 0);
        check_output({tag, "_sticky"}, ovf_sticky, 0);
        check_output({tag, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        ovf_clr   = '0;
        #2;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);

        // Basic product and two-cycle latency
        rsp_ready = 1'b1;
        set_operands(0, 16'h1800, 16'h2000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        #1;
        check_output("latency_early", rsp_valid, 0);
        step();
        check_output("latency_valid", rsp_valid, 1);
        drain(8);
        check_output("t1_id", last_id, 0);
        check_output("t1_result", last_result, 16'h3000);
        check_output("t1_ovf", last_ovf, 0);

        // Negative operand, then the zero-times-negative artifact
        apply_stimulus(2, 16'hE800, 16'h2000);
        check_output("t2_id", last_id, 2);
        check_output("t2_result", last_result, 16'hD000);
        apply_stimulus(2, 16'h0000, 16'hE800);
        check_output("t2_zero_neg", last_result, 16'h8000);

        // Overflow and sticky status
        apply_stimulus(1, 16'h4000, 16'h2000);
        check_output("t3_result", last_result, 16'h0000);
        check_output("t3_ovf", last_ovf, 1);
        check_output("t3_sticky", ovf_sticky, 4'b0010);
        ovf_clr = 4'b0010;
        step();
        ovf_clr = '0;
        check_output("t3_sticky_clr", ovf_sticky, 4'b0000);

        // All requesters valid, full throughput
        n_acc     = 0;
        n_rsp     = 0;
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (12) begin
            randomize_operands();
            step();
        end
        req_valid = '0;
        check_output("t4_accepts", n_acc, 12);
        check_output("t4_rsp_in_window", n_rsp, 10);
        drain(8);
        check_output("t4_responses", n_rsp, 12);

        // Response backpressure with continuous requests
        n_acc     = 0;
        n_rsp     = 0;
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (5) begin
            randomize_operands();
            step();
        end
        check_output("t5_stall_accepts", n_acc, 2);
        #1;
        check_output("t5_stall_ready", req_ready, 0);
        rsp_ready = 1'b1;
        repeat (6) begin
            randomize_operands();
            step();
        end
        req_valid = '0;
        drain(8);
        check_output("t5_no_loss", n_rsp, n_acc);

        // Reset with two products in flight
        rsp_ready = 1'b0;
        set_operands(1, 16'h1000, 16'h1000);
        set_operands(2, 16'h2000, 16'h1800);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        check_reset_values("midreset");
        sb_q.delete();
        model_rr   = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) begin
            step();
            check_output("post_reset_idle", rsp_valid, 0);
        end
        set_operands(1, 16'h1000, 16'h2000);
        set_operands(3, 16'h1000, 16'h3000);
        req_valid = 4'b1010;
        step();
        req_valid = '0;
        drain(8);
        check_output("t6_rr_restart_id", last_id, 1);
        check_output("t6_result", last_result, 16'h2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
